// File: rtl/mem_stage_sram_pkg.sv
// mem_stage_sram_pkg
// Shared constants, FSM state encoding and the address-mapping helper for the
// ARM memory stage that talks to a 16-bit external SRAM.
// No ports (package).

package mem_stage_sram_pkg;

   localparam int SRAM_ADDR_LEN             = 18;
   localparam int SRAM_DATA_LEN             = 16;
   localparam int DATA_MEM_BASE             = 1024;
   localparam int REGISTER_FILE_LEN         = 32;
   localparam int REGISTER_FILE_ADDRESS_LEN = 4;
   // One 32-bit word occupies two consecutive half-word SRAM locations.
   localparam int WORD_INDEX_LEN            = SRAM_ADDR_LEN - 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Byte address to SRAM word index. Addresses below the base wrap modulo
   // 2^WORD_INDEX_LEN instead of faulting.
   function automatic logic [WORD_INDEX_LEN-1:0] word_index(
      input logic [REGISTER_FILE_LEN-1:0] byte_addr,
      input logic [REGISTER_FILE_LEN-1:0] base_addr
   );
      return WORD_INDEX_LEN'((byte_addr - base_addr) >> 2);
   endfunction

endpackage

// File: rtl/mem_stage_sram_if.sv
// mem_stage_sram_if
// Bundle of the external 16-bit SRAM pins.
//   sram_addr   half-word address         (master -> slave)
//   sram_wdata  write data                (master -> slave)
//   sram_we_n   active-low write strobe   (master -> slave)
//   sram_oe_n   active-low output enable  (master -> slave)
//   sram_rdata  read data, valid while sram_oe_n = 0 (slave -> master)

interface mem_stage_sram_if;
   import mem_stage_sram_pkg::*;

   logic [SRAM_ADDR_LEN-1:0] sram_addr;
   logic [SRAM_DATA_LEN-1:0] sram_wdata;
   logic [SRAM_DATA_LEN-1:0] sram_rdata;
   logic                     sram_we_n;
   logic                     sram_oe_n;

   modport master (
      output sram_addr, sram_wdata, sram_we_n, sram_oe_n,
      input  sram_rdata
   );

   modport slave (
      input  sram_addr, sram_wdata, sram_we_n, sram_oe_n,
      output sram_rdata
   );

endinterface

// File: rtl/mem_stage_sram_mem_wb_reg.sv
// mem_stage_sram_mem_wb_reg
// MEM/WB pipeline register. When load_i is high every field takes its input;
// when low a bubble is inserted: the two enables clear, the data fields hold.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset (all fields 0)
//   load_i                  1 = load, 0 = bubble
//   wb_en_i, mem_r_en_i     control in
//   alu_res_i, mem_data_i   data in
//   dest_i                  destination register in
//   *_o                     registered copies to writeback

module mem_stage_sram_mem_wb_reg
   import mem_stage_sram_pkg::*;
(
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 load_i,
   input  logic                                 wb_en_i,
   input  logic                                 mem_r_en_i,
   input  logic [REGISTER_FILE_LEN-1:0]         alu_res_i,
   input  logic [REGISTER_FILE_LEN-1:0]         mem_data_i,
   input  logic [REGISTER_FILE_ADDRESS_LEN-1:0] dest_i,
   output logic                                 wb_en_o,
   output logic                                 mem_r_en_o,
   output logic [REGISTER_FILE_LEN-1:0]         alu_res_o,
   output logic [REGISTER_FILE_LEN-1:0]         mem_data_o,
   output logic [REGISTER_FILE_ADDRESS_LEN-1:0] dest_o
);

   logic                                 wb_en_q,    wb_en_d;
   logic                                 mem_r_en_q, mem_r_en_d;
   logic [REGISTER_FILE_LEN-1:0]         alu_res_q,  alu_res_d;
   logic [REGISTER_FILE_LEN-1:0]         mem_data_q, mem_data_d;
   logic [REGISTER_FILE_ADDRESS_LEN-1:0] dest_q,     dest_d;

   always_comb begin
      wb_en_d    = 1'b0;
      mem_r_en_d = 1'b0;
      alu_res_d  = alu_res_q;
      mem_data_d = mem_data_q;
      dest_d     = dest_q;
      if (load_i) begin
         wb_en_d    = wb_en_i;
         mem_r_en_d = mem_r_en_i;
         alu_res_d  = alu_res_i;
         mem_data_d = mem_data_i;
         dest_d     = dest_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_en_q    <= 1'b0;
         mem_r_en_q <= 1'b0;
         alu_res_q  <= '0;
         mem_data_q <= '0;
         dest_q     <= '0;
      end else begin
         wb_en_q    <= wb_en_d;
         mem_r_en_q <= mem_r_en_d;
         alu_res_q  <= alu_res_d;
         mem_data_q <= mem_data_d;
         dest_q     <= dest_d;
      end
   end

   assign wb_en_o    = wb_en_q;
   assign mem_r_en_o = mem_r_en_q;
   assign alu_res_o  = alu_res_q;
   assign mem_data_o = mem_data_q;
   assign dest_o     = dest_q;

endmodule

// File: rtl/mem_stage_sram.sv
// mem_stage_sram
// ARM memory stage. Performs a 32-bit load/store as two half-word accesses on
// a 16-bit SRAM (low half first), each held for WAIT_CYCLES clocks, and
// freezes the upstream pipeline through `ready` while the access is running.
// Non-memory instructions pass straight into MEM/WB without stalling.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   wb_en_in, mem_r_en_in,
//   mem_w_en_in              EXE/MEM controls (write wins if both enables set)
//   alu_res_in               byte address (memory ops) or ALU result
//   val_r_m_in               store data
//   dest_in                  destination register
//   ready                    pipeline advance qualifier (see below)
//   sram                     SRAM pin bundle (master side)
//   wb_en_out, mem_r_en_out,
//   alu_res_out, mem_data_out,
//   dest_out                 MEM/WB register outputs
//   dbg_state_o              current FSM state, observation only
//
// Handshake: `ready` is a combinational enable for every upstream pipeline
// register and for MEM/WB. ready=1 means the instruction currently presented
// on the EXE/MEM inputs is consumed at the next rising edge. ready=0 means it
// is not consumed: upstream must hold it unchanged, and MEM/WB receives a
// bubble. ready is 1 in DONE, or in IDLE when no memory enable is set.

module mem_stage_sram
   import mem_stage_sram_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int BASE_ADDR   = DATA_MEM_BASE
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 wb_en_in,
   input  logic                                 mem_r_en_in,
   input  logic                                 mem_w_en_in,
   input  logic [REGISTER_FILE_LEN-1:0]         alu_res_in,
   input  logic [REGISTER_FILE_LEN-1:0]         val_r_m_in,
   input  logic [REGISTER_FILE_ADDRESS_LEN-1:0] dest_in,
   output logic                                 ready,
   mem_stage_sram_if.master                     sram,
   output logic                                 wb_en_out,
   output logic                                 mem_r_en_out,
   output logic [REGISTER_FILE_LEN-1:0]         alu_res_out,
   output logic [REGISTER_FILE_LEN-1:0]         mem_data_out,
   output logic [REGISTER_FILE_ADDRESS_LEN-1:0] dest_out,
   output state_t                               dbg_state_o
);

   localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

   state_t                       state_q;
   logic [3:0]                   cnt_q;
   logic [REGISTER_FILE_LEN-1:0] data_q;
   logic [SRAM_ADDR_LEN-1:0]     addr_q;
   logic [SRAM_DATA_LEN-1:0]     wdata_q;
   logic                         we_n_q;
   logic                         oe_n_q;

   logic                         mem_req;
   logic [WORD_INDEX_LEN-1:0]    idx;
   logic [REGISTER_FILE_LEN-1:0] mem_data_sel;

   assign mem_req = mem_r_en_in | mem_w_en_in;
   // The EXE/MEM inputs are frozen for the whole access, so the address can
   // be recomputed from them in every phase rather than latched.
   assign idx     = word_index(alu_res_in, REGISTER_FILE_LEN'(BASE_ADDR));

   assign ready = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !mem_req);

   // Strobes, address and write data are registered: they are set on the
   // edge that enters LOW/HIGH and cleared on the edge that enters DONE, so
   // they are asserted for exactly WAIT_CYCLES clocks per half.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (mem_req) begin
                  state_q <= ST_LOW;
                  cnt_q   <= '0;
                  // Cleared so a write (even with mem_r_en also set) never
                  // forwards stale read data to writeback.
                  data_q  <= '0;
                  addr_q  <= {idx, 1'b0};
                  wdata_q <= mem_w_en_in ? val_r_m_in[15:0] : '0;
                  we_n_q  <= !mem_w_en_in;
                  oe_n_q  <= mem_w_en_in;
               end
            end
            ST_LOW: begin
               if (cnt_q == CNT_LAST) begin
                  if (!oe_n_q) data_q[15:0] <= sram.sram_rdata;
                  state_q <= ST_HIGH;
                  cnt_q   <= '0;
                  addr_q  <= {idx, 1'b1};
                  wdata_q <= !we_n_q ? val_r_m_in[31:16] : '0;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            ST_HIGH: begin
               if (cnt_q == CNT_LAST) begin
                  if (!oe_n_q) data_q[31:16] <= sram.sram_rdata;
                  state_q <= ST_DONE;
                  cnt_q   <= '0;
                  addr_q  <= '0;
                  wdata_q <= '0;
                  we_n_q  <= 1'b1;
                  oe_n_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign sram.sram_addr  = addr_q;
   assign sram.sram_wdata = wdata_q;
   assign sram.sram_we_n  = we_n_q;
   assign sram.sram_oe_n  = oe_n_q;
   assign dbg_state_o     = state_q;

   assign mem_data_sel = mem_r_en_in ? data_q : '0;

   mem_stage_sram_mem_wb_reg u_mem_wb_reg (
      .clk        (clk),
      .rst_n      (rst),
      .load_i     (ready),
      .wb_en_i    (wb_en_in),
      .mem_r_en_i (mem_r_en_in),
      .alu_res_i  (alu_res_in),
      .mem_data_i (mem_data_sel),
      .dest_i     (dest_in),
      .wb_en_o    (wb_en_out),
      .mem_r_en_o (mem_r_en_out),
      .alu_res_o  (alu_res_out),
      .mem_data_o (mem_data_out),
      .dest_o     (dest_out)
   );

endmodule

// File: tb/tb_mem_stage_sram.sv
// tb_mem_stage_sram
// Directed bench for mem_stage_sram (WAIT_CYCLES = 2, BASE_ADDR = 1024) with a
// behavioural 16-bit SRAM. Expected MEM/WB records and expected SRAM write
// cycles are queued by the driver and consumed by independent monitors.

module tb_mem_stage_sram;
   import mem_stage_sram_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT ----------------
   logic        wb_en_in, mem_r_en_in, mem_w_en_in;
   logic [31:0] alu_res_in, val_r_m_in;
   logic [3:0]  dest_in;
   logic        ready;
   logic        wb_en_out, mem_r_en_out;
   logic [31:0] alu_res_out, mem_data_out;
   logic [3:0]  dest_out;
   state_t      dbg_state;

   mem_stage_sram_if sif ();

   mem_stage_sram #(.WAIT_CYCLES(2), .BASE_ADDR(1024)) dut (
      .clk          (clk),
      .rst          (rst),
      .wb_en_in     (wb_en_in),
      .mem_r_en_in  (mem_r_en_in),
      .mem_w_en_in  (mem_w_en_in),
      .alu_res_in   (alu_res_in),
      .val_r_m_in   (val_r_m_in),
      .dest_in      (dest_in),
      .ready        (ready),
      .sram         (sif),
      .wb_en_out    (wb_en_out),
      .mem_r_en_out (mem_r_en_out),
      .alu_res_out  (alu_res_out),
      .mem_data_out (mem_data_out),
      .dest_out     (dest_out),
      .dbg_state_o  (dbg_state)
   );

   // ---------------- SRAM model ----------------
   logic [15:0] sram_mem [0:262143];
   always @(posedge clk) if (!sif.sram_we_n) sram_mem[sif.sram_addr] <= sif.sram_wdata;
   assign sif.sram_rdata = sif.sram_oe_n ? 16'h0000 : sram_mem[sif.sram_addr];

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [69:0] exp_q[$];   // {wb_en, mem_r_en, alu_res, mem_data, dest}
   logic [33:0] wr_q[$];    // {sram_addr, sram_wdata} per write-strobe cycle

   task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [69:0] rec(input logic wb, input logic r, input logic [31:0] alu,
                                       input logic [31:0] data, input logic [3:0] dst);
      return {wb, r, alu, data, dst};
   endfunction

   // MEM/WB monitor: a record is present after an edge where ready was 1;
   // after an edge where ready was 0 a bubble must be visible.
   logic out_loaded = 1'b0;
   always @(posedge clk) out_loaded <= ready && rst;

   always @(negedge clk) begin
      if (rst) begin
         if (out_loaded) begin
            if (wb_en_out || mem_r_en_out) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_record", {wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out}, 70'd0);
               end else begin
                  check("memwb_record", {wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out}, exp_q.pop_front());
               end
            end
         end else begin
            check("bubble", {68'd0, wb_en_out, mem_r_en_out}, 70'd0);
         end
      end
   end

   // SRAM write monitor
   always @(negedge clk) begin
      if (rst && !sif.sram_we_n) begin
         if (wr_q.size() == 0) begin
            check("unexpected_write", {36'd0, sif.sram_addr, sif.sram_wdata}, 70'd0);
         end else begin
            check("sram_write", {36'd0, sif.sram_addr, sif.sram_wdata}, {36'd0, wr_q.pop_front()});
         end
      end
   end

   // ---------------- driver ----------------
   task automatic set_idle();
      wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
      alu_res_in = 32'd0; val_r_m_in = 32'd0; dest_in = 4'd0;
   endtask

   task automatic push_writes(input logic [17:0] a, input logic [31:0] v);
      wr_q.push_back({a, v[15:0]});
      wr_q.push_back({a, v[15:0]});
      wr_q.push_back({a | 18'd1, v[31:16]});
      wr_q.push_back({a | 18'd1, v[31:16]});
   endtask

   // Presents one instruction and holds it until the DUT consumes it.
   task automatic issue(input string name, input logic wb, input logic r, input logic w,
                        input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dst,
                        input int exp_stalls);
      int  stalls;
      bit  seen;
      @(negedge clk);
      wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
      alu_res_in = alu; val_r_m_in = val; dest_in = dst;
      stalls = 0;
      seen   = 1'b0;
      for (int k = 0; k < 64; k++) begin
         #1;
         if (ready) begin
            seen = 1'b1;
            break;
         end
         stalls++;
         @(negedge clk);
      end
      check({name, "_accepted"}, {69'd0, seen}, 70'd1);
      check({name, "_stall_cycles"}, 70'(stalls), 70'(exp_stalls));
      @(posedge clk);
      #1;
      set_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   // ---------------- test sequence ----------------
   initial begin
      set_idle();
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_ready",  {69'd0, ready}, 70'd1);
      check("rst_we_n",   {69'd0, sif.sram_we_n}, 70'd1);
      check("rst_oe_n",   {69'd0, sif.sram_oe_n}, 70'd1);
      check("rst_state",  {68'd0, dbg_state}, {68'd0, ST_IDLE});
      check("rst_memwb",  {wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out}, 70'd0);
      rst = 1'b1;
      @(negedge clk);

      // ADD: no memory access, no stall
      exp_q.push_back(rec(1'b1, 1'b0, 32'h0000_00AA, 32'h0, 4'd3));
      issue("add", 1'b1, 1'b0, 1'b0, 32'h0000_00AA, 32'h0, 4'd3, 0);

      // Store 0xDEADBEEF at 1028 -> half-words 2 and 3
      push_writes(18'd2, 32'hDEAD_BEEF);
      issue("store1028", 1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 4'd0, 5);
      @(negedge clk);
      check("idle_addr", {52'd0, sif.sram_addr}, 70'd0);
      check("idle_we_n", {69'd0, sif.sram_we_n}, 70'd1);

      // Load back from 1028
      exp_q.push_back(rec(1'b1, 1'b1, 32'd1028, 32'hDEAD_BEEF, 4'd5));
      issue("load1028", 1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd5, 5);

      // Back-to-back store / load at 1040 -> half-words 8 and 9
      push_writes(18'd8, 32'hCAFE_1234);
      exp_q.push_back(rec(1'b1, 1'b1, 32'd1040, 32'hCAFE_1234, 4'd7));
      issue("b2b_store", 1'b0, 1'b0, 1'b1, 32'd1040, 32'hCAFE_1234, 4'd0, 5);
      issue("b2b_load",  1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 4'd7, 5);

      // Below base with both enables: write wins, wraps to 0x3FFFE/0x3FFFF
      push_writes(18'h3FFFE, 32'h0BAD_F00D);
      exp_q.push_back(rec(1'b0, 1'b1, 32'd1020, 32'h0, 4'd2));
      issue("wrap_both", 1'b0, 1'b1, 1'b1, 32'd1020, 32'h0BAD_F00D, 4'd2, 5);
      exp_q.push_back(rec(1'b1, 1'b1, 32'd1020, 32'h0BAD_F00D, 4'd1));
      issue("wrap_load", 1'b1, 1'b1, 1'b0, 32'd1020, 32'h0, 4'd1, 5);

      // Reset in the middle of the low half of a store at 1024
      wr_q.push_back({18'd0, 16'h5678});
      @(negedge clk);
      wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b1;
      alu_res_in = 32'd1024; val_r_m_in = 32'h1234_5678; dest_in = 4'd0;
      @(negedge clk);
      #2;
      check("mid_low_state", {68'd0, dbg_state}, {68'd0, ST_LOW});
      rst = 1'b0;
      #1;
      check("midrst_state", {68'd0, dbg_state}, {68'd0, ST_IDLE});
      check("midrst_we_n",  {69'd0, sif.sram_we_n}, 70'd1);
      check("midrst_oe_n",  {69'd0, sif.sram_oe_n}, 70'd1);
      check("midrst_addr",  {52'd0, sif.sram_addr}, 70'd0);
      check("midrst_memwb", {wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out}, 70'd0);
      check("midrst_ready_req", {69'd0, ready}, 70'd0);
      set_idle();
      #1;
      check("midrst_ready_idle", {69'd0, ready}, 70'd1);
      @(negedge clk);
      rst = 1'b1;

      // Recovery after reset
      exp_q.push_back(rec(1'b1, 1'b0, 32'h0000_0055, 32'h0, 4'd9));
      issue("add_after_rst", 1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'h0, 4'd9, 0);

      repeat (4) @(negedge clk);
      check("exp_q_drained", 70'(exp_q.size()), 70'd0);
      check("wr_q_drained",  70'(wr_q.size()), 70'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
